// File: rtl/conv_input_ctrl.sv
// conv_input_ctrl
//   Front end for the conversion display stage. Synchronises and debounces
//   three active-low pushbuttons, latches the selected display mode
//   (BIN/DEC/HEX) so it holds after release, and produces a 4-bit value from a
//   free-running prescaled up/down counter.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   btn_n[2:0] raw active-low buttons: [0]=BIN [1]=DEC [2]=HEX
//   run        counter steps on ticks when 1
//   up         count direction: 1 up, 0 down
//   clr        holds counter and prescaler at 0 when 1
//   mode_out   latched mode, active-low one-hot (3'b111 = none selected)
//   value_out  current counter value
//   tick_out   one-cycle pulse on each counter step

// conv_input_db
//   One button lane: 2-flop synchroniser, stable-count debouncer, and
//   falling-edge (press) detection on the debounced state.
//
// Ports
//   clk, rst   as above
//   btn_n_raw  raw active-low button
//   press      one-cycle pulse when the debounced state falls 1->0
module conv_input_db #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q, sync_d;
    logic          db_q, db_d;
    logic          db_prev_q, db_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d    = {sync_q[0], btn_n_raw};
        db_prev_d = db_q;
        db_d      = db_q;
        cnt_d     = '0;
        // Count only while the synced input disagrees; any agreement restarts.
        if (sync_q[1] != db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            db_q      <= 1'b1;
            db_prev_q <= 1'b1;
            cnt_q     <= '0;
        end else begin
            sync_q    <= sync_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            cnt_q     <= cnt_d;
        end
    end

    assign press = db_prev_q & ~db_q;
endmodule

module conv_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_CYCLES     = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn_n,
    input  logic       run,
    input  logic       up,
    input  logic       clr,
    output logic [2:0] mode_out,
    output logic [3:0] value_out,
    output logic       tick_out
);
    // Keep at least one prescaler bit so TICK_CYCLES=1 still elaborates.
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [2:0]    press;
    logic [2:0]    ctl_s1_q, ctl_s1_d;   // {clr, up, run}
    logic [2:0]    ctl_s2_q, ctl_s2_d;
    logic [2:0]    mode_q, mode_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    value_q, value_d;
    logic          tick_q, tick_d;
    logic          run_s, up_s, clr_s;

    for (genvar i = 0; i < 3; i++) begin : g_btn
        conv_input_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk       (clk),
            .rst       (rst),
            .btn_n_raw (btn_n[i]),
            .press     (press[i])
        );
    end

    assign run_s = ctl_s2_q[0];
    assign up_s  = ctl_s2_q[1];
    assign clr_s = ctl_s2_q[2];

    always_comb begin
        ctl_s1_d = {clr, up, run};
        ctl_s2_d = ctl_s1_q;

        // Highest-numbered press wins; releases never touch the mode.
        mode_d = mode_q;
        if (press[2])      mode_d = 3'b011;
        else if (press[1]) mode_d = 3'b101;
        else if (press[0]) mode_d = 3'b110;

        presc_d = presc_q;
        value_d = value_q;
        tick_d  = 1'b0;
        if (clr_s) begin
            presc_d = '0;
            value_d = 4'd0;
        end else if (run_s) begin
            if (presc_q == PW'(TICK_CYCLES - 1)) begin
                presc_d = '0;
                tick_d  = 1'b1;
                value_d = up_s ? value_q + 4'd1 : value_q - 4'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl_s1_q <= '0;
            ctl_s2_q <= '0;
            mode_q   <= 3'b111;
            presc_q  <= '0;
            value_q  <= '0;
            tick_q   <= 1'b0;
        end else begin
            ctl_s1_q <= ctl_s1_d;
            ctl_s2_q <= ctl_s2_d;
            mode_q   <= mode_d;
            presc_q  <= presc_d;
            value_q  <= value_d;
            tick_q   <= tick_d;
        end
    end

    assign mode_out  = mode_q;
    assign value_out = value_q;
    assign tick_out  = tick_q;
endmodule

// File: doc/conv_input_ctrl.md
Name: conv_input_ctrl

Overview:
Upstream front end for the conversion display stage. It synchronises and debounces the three raw active-low pushbuttons and latches the chosen display mode (BIN/DEC/HEX) so the mode holds after release. It also generates the 4-bit source value with a free-running, prescaled up/down counter. Its mode_out and value_out feed the display stage's btn[2:0] and sw[3:0] inputs directly.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a button change (10 ms at 50 MHz); minimum 2.
TICK_CYCLES, 50000000, clock cycles per counter step while running (1 Hz at 50 MHz); minimum 1.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
btn_n  input  3  raw pushbuttons, active-low, asynchronous; [0]=BIN, [1]=DEC, [2]=HEX
run  input  1  slide switch, asynchronous; 1 = counter steps on ticks
up  input  1  slide switch, asynchronous; 1 = count up, 0 = count down
clr  input  1  slide switch, asynchronous; 1 = hold counter at 0
mode_out  output  3  latched mode, active-low one-hot: 3'b110 BIN, 3'b101 DEC, 3'b011 HEX, 3'b111 none
value_out  output  4  current counter value
tick_out  output  1  one-cycle pulse on each counter step

Behaviour:
- Reset (async, rst=1) forces these values, held while rst=1:
  - mode_out=3'b111, value_out=0, tick_out=0, prescaler=0.
  - All debounce counters=0.
  - All synchroniser flops and debounced button states=1 (released). run/up/clr synchroniser flops=0.
- Synchronisers: each of btn_n[2:0], run, up, clr passes through 2 flops. Only synchronised versions are used downstream.
- Debounce (independent per button):
  - Counter clears whenever the synchronised input equals the debounced state.
  - Otherwise it increments each cycle.
  - When it is at DEBOUNCE_CYCLES-1 and the input still differs, the debounced state takes the input value at that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Press event: the debounced state falls 1->0, detected against a registered copy of the debounced state.
- Mode register update (at the edge following the debounced fall):
  - Press 2 -> 3'b011, press 1 -> 3'b101, press 0 -> 3'b110.
  - Simultaneous events: priority 2 > 1 > 0.
  - Releases and re-pressing the active button leave mode_out unchanged. Mode persists until a different press or reset.
- Latency: with btn_n held low and first sampled at edge 1, mode_out changes at edge DEBOUNCE_CYCLES+3. Release is debounced identically but causes no output change.
- Prescaler:
  - Counts 0..TICK_CYCLES-1 while synced run=1 and synced clr=0, then wraps to 0.
  - The wrap cycle asserts tick_out=1 for exactly one cycle, and value_out updates on that same edge.
  - With TICK_CYCLES=1, a tick occurs every cycle while running.
- Value arithmetic (4-bit modulo):
  - On a tick with up=1: value+1, 15 wraps to 0.
  - On a tick with up=0: value-1, 0 wraps to 15.
  - up is sampled synchronised at the tick edge.
- run=0: prescaler and value freeze, no ticks. Resuming continues from the frozen prescaler count.
- clr=1 (synced): value_out=0, prescaler=0, tick_out=0 every cycle. Overrides run; a tick coincident with clr is suppressed.
- Mode and counter paths are independent: button activity never disturbs value_out, and vice versa.
- Reset asserted mid-debounce or mid-count aborts immediately. After release, all behaviour restarts from reset values.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, TICK_CYCLES=3.)
- Reset, then hold btn_n=3'b101 -> mode_out goes 3'b111 to 3'b101 exactly 7 edges after first sampled low. Release -> mode_out stays 3'b101.
- btn_n[0] low for 3 cycles then high (bounce), repeated 5 times -> mode_out unchanged 3'b111. Then hold low for 6 cycles -> 3'b110.
- btn_n[2] and btn_n[0] pulled low on the same cycle -> mode_out=3'b011, never 3'b110 at any cycle.
- run=1, up=1 from value 0 -> tick_out every 3rd cycle. value_out steps 1,2,...,15,0. Wrap 15->0 coincides with a tick.
- run=1, up=0 from 0 -> value_out 15,14. Set run=0 for 10 cycles -> value and tick frozen. Set clr=1 -> value_out=0 two cycles after clr rises (sync), with no tick while clr=1.
- Assert rst mid-count (value 9) and mid-debounce (counter 2) -> value_out=0, mode_out=3'b111, tick_out=0 immediately without a clock edge. Held button re-debounces a full 7 edges after rst drops.
